// File: rtl/axi_dmem_slave.sv
// AXI4-Lite subordinate wrapping a word-organised on-chip RAM for the core's data-memory port.
// One transaction per channel at a time; AW/W are held independently and the write commits when both are present.
module axi_dmem_slave #(
  parameter int                    AXI_AWIDTH = 32,
  parameter int                    AXI_DWIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [AXI_AWIDTH-1:0] BASE_ADDR  = '0,
  parameter string                 INIT_FILE  = ""
) (
  input  logic                    CLK,
  input  logic                    NRST,
  input  logic [AXI_AWIDTH-1:0]   S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [AXI_AWIDTH-1:0]   S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = AXI_DWIDTH / 8;
  localparam logic [AXI_AWIDTH:0] MEM_BYTES = (AXI_AWIDTH + 1)'(4 * MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  logic [AXI_DWIDTH-1:0] mem [MEM_DEPTH];

  // Offset from the base at one extra bit: an address below the base wraps to a huge
  // offset, so a single unsigned compare covers both bounds without upper-bound wrap.
  function automatic logic [AXI_AWIDTH:0] addr_offset(input logic [AXI_AWIDTH-1:0] a);
    return {1'b0, a} - {1'b0, BASE_ADDR};
  endfunction

  function automatic logic addr_hit(input logic [AXI_AWIDTH-1:0] a);
    return addr_offset(a) < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [AXI_AWIDTH-1:0] a);
    return IDX_W'(addr_offset(a) >> 2);
  endfunction

  logic                  aw_full, w_full;
  logic [AXI_AWIDTH-1:0] aw_addr_q;
  logic [AXI_DWIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic                  aw_hs, w_hs, commit, wr_hit;
  logic [AXI_AWIDTH-1:0] wr_addr;
  logic [AXI_DWIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx;

  assign S_AXI_AWREADY = !aw_full && !bvalid_q;
  assign S_AXI_WREADY  = !w_full && !bvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

  // A beat arriving this cycle counts as held, so the commit lands on the later handshake edge.
  assign commit  = NRST && (aw_full || aw_hs) && (w_full || w_hs);
  assign wr_addr = aw_full ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data = w_full ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_full ? w_strb_q : S_AXI_WSTRB;
  assign wr_hit  = addr_hit(wr_addr);
  assign wr_idx  = addr_index(wr_addr);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (commit) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_full   <= 1'b1;
          aw_addr_q <= S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_full   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
      end
    end
  end

  // RAM contents are deliberately not reset and survive NRST.
  always_ff @(posedge CLK) begin
    if (commit && wr_hit) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_strb[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  r_state_t              r_state, r_state_next;
  logic                  rd_capture;
  logic [AXI_DWIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  assign S_AXI_ARREADY = (r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_state == R_RESP);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  always_comb begin
    r_state_next = r_state;
    rd_capture   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (S_AXI_ARVALID) begin
          rd_capture   = 1'b1;
          r_state_next = R_RESP;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          r_state_next = R_IDLE;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Nonblocking capture sees the pre-write word when a commit hits the same edge.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      r_state <= r_state_next;
      if (rd_capture) begin
        if (addr_hit(S_AXI_ARADDR)) begin
          rdata_q <= mem[addr_index(S_AXI_ARADDR)];
          rresp_q <= RESP_OKAY;
        end else begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_dmem_slave.sv
// Scoreboard bench for axi_dmem_slave: drivers push expected responses, a negedge monitor pops and compares.
// The reference memory is a plain word array updated with byte-merge arithmetic at issue time.
module tb_axi_dmem_slave;

  logic        CLK, NRST;
  logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;

  axi_dmem_slave dut (
    .CLK(CLK), .NRST(NRST),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic [1:0]  bq[$];
  r_exp_t      rq[$];
  logic [31:0] model [1024];
  int          n_cmp = 0;
  int          n_err = 0;
  int          b_mode = 0;
  int          r_mode = 0;
  logic [1:0]  mon_b;
  r_exp_t      mon_r;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic report_unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("[TB] FAIL %s: response seen, expected none queued", name);
  endtask

  // Reference rules: in range iff byte address < 4*1024 (base 0), word index = addr/4.
  function automatic bit in_range(input logic [31:0] a);
    return a < 32'h0000_1000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic pick_ready(input int mode);
    if (mode == 2) return 1'b1;
    if (mode == 1) return 1'b0;
    return $urandom_range(0, 3) != 0;
  endfunction

  initial begin
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      S_AXI_BREADY = pick_ready(b_mode);
      S_AXI_RREADY = pick_ready(r_mode);
    end
  end

  // Monitor: a response is compared on the cycle its handshake completes.
  always @(negedge CLK) begin
    if (NRST) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) report_unexpected("b_unexpected");
        else begin
          mon_b = bq.pop_front();
          check_eq("bresp", {30'd0, S_AXI_BRESP}, {30'd0, mon_b});
        end
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) report_unexpected("r_unexpected");
        else begin
          mon_r = rq.pop_front();
          check_eq("rdata", S_AXI_RDATA, mon_r.data);
          check_eq("rresp", {30'd0, S_AXI_RRESP}, {30'd0, mon_r.resp});
        end
      end
    end
  end

  task automatic send_aw(input logic [31:0] addr, input int dly);
    bit done;
    done = 0;
    repeat (dly) begin @(posedge CLK); #1; end
    S_AXI_AWADDR  = addr;
    S_AXI_AWVALID = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge CLK);
      done = S_AXI_AWREADY;
      @(posedge CLK);
      #1;
    end
    S_AXI_AWVALID = 1'b0;
    check_eq("aw_handshake", {31'd0, done}, 32'd1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    bit done;
    done = 0;
    repeat (dly) begin @(posedge CLK); #1; end
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    S_AXI_WVALID = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge CLK);
      done = S_AXI_WREADY;
      @(posedge CLK);
      #1;
    end
    S_AXI_WVALID = 1'b0;
    check_eq("w_handshake", {31'd0, done}, 32'd1);
  endtask

  task automatic send_ar(input logic [31:0] addr, input int dly);
    bit done;
    done = 0;
    repeat (dly) begin @(posedge CLK); #1; end
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge CLK);
      done = S_AXI_ARREADY;
      @(posedge CLK);
      #1;
    end
    S_AXI_ARVALID = 1'b0;
    check_eq("ar_handshake", {31'd0, done}, 32'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 200; c++) begin
      if (bq.size() == 0 && rq.size() == 0) break;
      @(posedge CLK);
      #1;
    end
    check_eq("drain", bq.size() + rq.size(), 32'd0);
    bq.delete();
    rq.delete();
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (in_range(addr)) begin
      bq.push_back(2'b00);
      model[addr[11:2]] = merge(model[addr[11:2]], data, strb);
    end else begin
      bq.push_back(2'b10);
    end
  endtask

  task automatic push_read(input logic [31:0] addr);
    if (in_range(addr)) rq.push_back('{data: model[addr[11:2]], resp: 2'b00});
    else rq.push_back('{data: 32'd0, resp: 2'b10});
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly);
    push_write(addr, data, strb);
    fork
      send_aw(addr, aw_dly);
      send_w(data, strb, w_dly);
    join
    @(negedge CLK);
    check_eq("b_latency", {31'd0, S_AXI_BVALID}, 32'd1);
    @(posedge CLK);
    #1;
    drain();
  endtask

  task automatic do_read(input logic [31:0] addr, input int dly);
    push_read(addr);
    send_ar(addr, dly);
    @(negedge CLK);
    check_eq("r_latency", {31'd0, S_AXI_RVALID}, 32'd1);
    check_eq("arready_busy", {31'd0, S_AXI_ARREADY}, 32'd0);
    @(posedge CLK);
    #1;
    drain();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_bvalid"}, {31'd0, S_AXI_BVALID}, 32'd0);
    check_eq({tag, "_rvalid"}, {31'd0, S_AXI_RVALID}, 32'd0);
    check_eq({tag, "_awready"}, {31'd0, S_AXI_AWREADY}, 32'd1);
    check_eq({tag, "_wready"}, {31'd0, S_AXI_WREADY}, 32'd1);
    check_eq({tag, "_arready"}, {31'd0, S_AXI_ARREADY}, 32'd1);
  endtask

  task automatic applyStimulus();
    logic [31:0] addr, d;
    logic        bv, rv;
    logic [1:0]  br, rr;
    logic [31:0] rd;

    for (int i = 0; i < 64; i++) do_write(32'(i * 4), 32'd0, 4'hF, 0, 0);

    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_read(32'h10, 0);

    do_write(32'h20, 32'h1122_3344, 4'hF, 0, 0);
    do_write(32'h20, 32'hAABB_CCDD, 4'b0101, 2, 0);
    do_read(32'h20, 0);
    check_eq("strobe_model", model[8], 32'h11BB_33DD);

    do_write(32'h1000, 32'h1234_5678, 4'hF, 0, 0);
    do_read(32'h0, 0);
    do_read(32'hFFFF_FFFC, 0);

    // Backpressure: both responses held while readies are forced low.
    b_mode = 1;
    r_mode = 1;
    d = $urandom;
    push_write(32'h80, d, 4'hF);
    push_read(32'h10);
    fork
      send_aw(32'h80, 0);
      send_w(d, 4'hF, 0);
      send_ar(32'h10, 0);
    join
    @(negedge CLK);
    bv = S_AXI_BVALID; br = S_AXI_BRESP; rv = S_AXI_RVALID; rd = S_AXI_RDATA; rr = S_AXI_RRESP;
    check_eq("bp_bvalid", {31'd0, bv}, 32'd1);
    check_eq("bp_rvalid", {31'd0, rv}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check_eq("bp_bvalid_hold", {31'd0, S_AXI_BVALID}, {31'd0, bv});
      check_eq("bp_bresp_hold", {30'd0, S_AXI_BRESP}, {30'd0, br});
      check_eq("bp_rvalid_hold", {31'd0, S_AXI_RVALID}, {31'd0, rv});
      check_eq("bp_rdata_hold", S_AXI_RDATA, rd);
      check_eq("bp_rresp_hold", {30'd0, S_AXI_RRESP}, {30'd0, rr});
      check_eq("bp_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
      check_eq("bp_wready", {31'd0, S_AXI_WREADY}, 32'd0);
      check_eq("bp_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
    end
    @(posedge CLK);
    #1;
    b_mode = 2;
    r_mode = 2;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check_idle_outputs("bp_release");
    @(posedge CLK);
    #1;
    b_mode = 0;
    r_mode = 0;
    drain();

    // Collision: read capture and write commit on the same edge.
    push_read(32'h30);
    push_write(32'h30, 32'h55, 4'hF);
    fork
      send_aw(32'h30, 0);
      send_w(32'h55, 4'hF, 0);
      send_ar(32'h30, 0);
    join
    @(negedge CLK);
    check_eq("coll_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
    check_eq("coll_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
    @(posedge CLK);
    #1;
    drain();
    do_read(32'h30, 0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 2))
          0: addr = 32'h1000 + 32'($urandom_range(0, 255) * 4);
          1: addr = 32'hFFFF_FFFC;
          default: addr = $urandom | 32'h0000_1000;
        endcase
      end else begin
        addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 0)
        do_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(addr, $urandom_range(0, 2));
    end
  endtask

  task automatic checkOutput();
    // Reset mid-transaction: AW held and a read response outstanding when NRST drops.
    r_mode = 1;
    fork
      send_aw(32'h40, 0);
      send_ar(32'h44, 0);
    join
    #2;
    NRST = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(posedge CLK);
    @(posedge CLK);
    #1;
    NRST = 1'b1;
    r_mode = 0;
    send_w(32'hCAFE_F00D, 4'hF, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check_eq("no_b_after_reset", {31'd0, S_AXI_BVALID}, 32'd0);
    end
    @(posedge CLK);
    #1;
    NRST = 1'b0;
    #1;
    check_eq("reset_wready", {31'd0, S_AXI_WREADY}, 32'd1);
    @(posedge CLK);
    #1;
    NRST = 1'b1;
    @(negedge CLK);
    check_idle_outputs("post_reset");
    @(posedge CLK);
    #1;
    do_read(32'h40, 0);
    check_eq("final_bq", bq.size(), 32'd0);
    check_eq("final_rq", rq.size(), 32'd0);
  endtask

  initial begin
    NRST = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
    @(negedge CLK);
    check_idle_outputs("in_reset");
    check_eq("in_reset_bresp", {30'd0, S_AXI_BRESP}, 32'd0);
    check_eq("in_reset_rresp", {30'd0, S_AXI_RRESP}, 32'd0);
    check_eq("in_reset_rdata", S_AXI_RDATA, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    NRST = 1'b1;
    @(negedge CLK);
    check_idle_outputs("after_reset");
    @(posedge CLK);
    #1;
    $display("[TB] starting stimulus");
    applyStimulus();
    checkOutput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
